simd_divider: RTL and testbench



---
 rtl/simd_divider.sv | 169 ++++++++++++++++
 tb/tb_simd_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/simd_divider.sv
// rtl/simd_divider.sv - packed-SIMD iterative integer divider, one quotient bit per element per cycle
//
// Divides every 8/16/32/64-bit element of a 64-bit operand pair in parallel
// using restoring division on magnitudes, then applies RISC-V sign,
// divide-by-zero and signed-overflow rules to each element.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i/ready_o   operand handshake (accept when both high)
//   signed_i, rem_i   signed division / return remainder instead of quotient
//   sew               one-hot element width (bit k = MIN_WIDTH<<k), else MAX_WIDTH
//   opA, opB          packed dividends / divisors
//   valid_o/ready_i   result handshake
//   result            packed quotients or remainders
`timescale 1ns/1ps
module simd_divider #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 signed_i,
  input  logic                 rem_i,
  input  logic [SEW_WIDTH-1:0] sew,
  input  logic [MAX_WIDTH-1:0] opA,
  input  logic [MAX_WIDTH-1:0] opB,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAX_WIDTH-1:0] result
);

  localparam int NW = SEW_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(MAX_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q;
  logic [IW-1:0]        idx_q;      // decoded element width index
  logic                 signed_q;
  logic                 rem_q;
  logic [CW-1:0]        cnt_q;
  logic [MAX_WIDTH-1:0] opa_q;      // original operands, needed for signs and corner cases
  logic [MAX_WIDTH-1:0] opb_q;
  logic [MAX_WIDTH-1:0] r_q;        // partial remainders
  logic [MAX_WIDTH-1:0] d_q;        // dividend magnitudes shifting out, quotient bits shifting in
  logic [MAX_WIDTH-1:0] b_q;        // divisor magnitudes
  logic [MAX_WIDTH-1:0] result_q;

  // One candidate datapath per element width; the latched width selects.
  wire  [MAX_WIDTH-1:0] ld_a [NW];
  wire  [MAX_WIDTH-1:0] ld_b [NW];
  wire  [MAX_WIDTH-1:0] st_r [NW];
  wire  [MAX_WIDTH-1:0] st_q [NW];
  wire  [MAX_WIDTH-1:0] fin  [NW];

  logic [IW-1:0]        sew_idx;
  logic                 accept;

  // Non-one-hot encodings fall back to the full datapath width.
  always_comb begin
    sew_idx = IW'(NW - 1);
    if ($onehot(sew)) begin
      for (int k = 0; k < NW; k++) begin
        if (sew[k]) sew_idx = IW'(k);
      end
    end
  end

  assign ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
  assign valid_o = (state_q == DONE);
  assign result  = result_q;
  assign accept  = valid_i & ready_o;

  for (genvar k = 0; k < NW; k++) begin : g_w
    localparam int W  = MIN_WIDTH << k;
    localparam int NE = MAX_WIDTH / W;
    for (genvar e = 0; e < NE; e++) begin : g_e
      localparam int L = e * W;

      // Operand magnitudes at accept time.
      logic [W-1:0] a_in, b_in;
      logic         a_neg, b_neg;
      assign a_in  = opA[L +: W];
      assign b_in  = opB[L +: W];
      assign a_neg = signed_i & a_in[W-1];
      assign b_neg = signed_i & b_in[W-1];
      assign ld_a[k][L +: W] = a_neg ? -a_in : a_in;
      assign ld_b[k][L +: W] = b_neg ? -b_in : b_in;

      // One restoring-division step confined to this element.
      logic [W:0]   r_sh;
      logic [W-1:0] diff, r_nx, q_nx, dvs;
      logic         ge;
      assign dvs  = b_q[L +: W];
      assign r_sh = {r_q[L +: W], d_q[L+W-1]};
      assign ge   = (r_sh >= {1'b0, dvs});
      // The true difference is below 2^W when ge is set, so W bits suffice.
      assign diff = r_sh[W-1:0] - dvs;
      assign r_nx = ge ? diff : r_sh[W-1:0];
      assign q_nx = {d_q[L +: W-1], ge};
      assign st_r[k][L +: W] = r_nx;
      assign st_q[k][L +: W] = q_nx;

      // Final sign fix-up and corner cases, applied to the last step's output.
      logic [W-1:0] xa, xb, q_s, r_s;
      logic         sa, sb, dz, ov;
      assign xa  = opa_q[L +: W];
      assign xb  = opb_q[L +: W];
      assign sa  = signed_q & xa[W-1];
      assign sb  = signed_q & xb[W-1];
      assign dz  = (xb == '0);
      assign ov  = signed_q & (xa == {1'b1, {(W-1){1'b0}}}) & (&xb);
      assign q_s = (sa ^ sb) ? -q_nx : q_nx;
      assign r_s = sa ? -r_nx : r_nx;
      // Divide-by-zero is checked first so it wins over overflow.
      assign fin[k][L +: W] = rem_q ? (dz ? xa : (ov ? '0 : r_s))
                                    : (dz ? '1 : (ov ? xa : q_s));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      r_q      <= '0;
      d_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (accept) begin
      // Covers both IDLE and the DONE-cycle handoff.
      idx_q    <= sew_idx;
      signed_q <= signed_i;
      rem_q    <= rem_i;
      opa_q    <= opA;
      opb_q    <= opB;
      r_q      <= '0;
      d_q      <= ld_a[sew_idx];
      b_q      <= ld_b[sew_idx];
      cnt_q    <= CW'(MIN_WIDTH << sew_idx);
      state_q  <= BUSY;
    end else begin
      case (state_q)
        BUSY: begin
          r_q   <= st_r[idx_q];
          d_q   <= st_q[idx_q];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= fin[idx_q];
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_divider.sv
// tb/tb_simd_divider.sv - directed-vector testbench for simd_divider
`timescale 1ns/1ps
module tb_simd_divider;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        signed_i;
  logic        rem_i;
  logic [3:0]  sew;
  logic [63:0] opA;
  logic [63:0] opB;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] E8  = 4'b0001;
  localparam logic [3:0] E16 = 4'b0010;
  localparam logic [3:0] E32 = 4'b0100;
  localparam logic [3:0] E64 = 4'b1000;

  localparam logic [63:0] A8  = 64'h649C_7F80_00FF_05F9;
  localparam logic [63:0] B8  = 64'h0707_FFFF_0003_0202;
  localparam logic [63:0] A16 = 64'hFC18_7FFF_1234_8000;
  localparam logic [63:0] B16 = 64'h0007_0010_0000_FFFF;
  localparam logic [63:0] A32 = 64'h8000_0001_FFFF_FFFF;
  localparam logic [63:0] B32 = 64'h0000_0002_FFFF_FFFF;

  simd_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .signed_i (signed_i),
    .rem_i    (rem_i),
    .sew      (sew),
    .opA      (opA),
    .opB      (opB),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sg, input logic rm, input logic [3:0] sw,
                       input logic [63:0] a, input logic [63:0] b);
    valid_i  = 1'b1;
    signed_i = sg;
    rem_i    = rm;
    sew      = sw;
    opA      = a;
    opB      = b;
  endtask

  // Called #1 after the accept edge; returns the number of edges until valid_o.
  task automatic wait_valid(output int lat, output logic rdy_busy);
    lat = 0;
    rdy_busy = 1'b0;
    while (!valid_o && lat < 300) begin
      if (ready_o) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic rm, input logic [3:0] sw,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    logic rdy_busy;
    @(negedge clk);
    drive(sg, rm, sw, a, b);
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_valid(lat, rdy_busy);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " ready_o busy"}, 64'(rdy_busy), 64'd0);
    check({tag, " result"}, result, exp_res);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    int   lat;
    logic rdy_busy;
    logic seen;

    rst_n = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    sew = E8; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready_o", 64'(ready_o), 64'd1);
    check("reset valid_o", 64'(valid_o), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit elements, incl. -7/2, x/-1, overflow, divide-by-zero, -1/3
    run_op("s8 quo", 1'b1, 1'b0, E8, A8, B8, 64'h0EF2_8180_FF00_02FD, 8);
    run_op("s8 rem", 1'b1, 1'b1, E8, A8, B8, 64'h02FE_0000_00FF_01FF, 8);
    run_op("u8 quo", 1'b0, 1'b0, E8, A8, B8, 64'h0E16_0000_FF55_027C, 8);
    run_op("u8 rem", 1'b0, 1'b1, E8, A8, B8, 64'h0202_7F80_0000_0101, 8);

    // 16-bit: overflow lane, zero-divisor lane, two ordinary lanes
    run_op("s16 quo", 1'b1, 1'b0, E16, A16, B16, 64'hFF72_07FF_FFFF_8000, 16);
    run_op("s16 rem", 1'b1, 1'b1, E16, A16, B16, 64'hFFFA_000F_1234_0000, 16);

    // 32-bit: -1/-1 and odd negative / 2
    run_op("s32 quo", 1'b1, 1'b0, E32, A32, B32, 64'hC000_0001_0000_0001, 32);
    run_op("s32 rem", 1'b1, 1'b1, E32, A32, B32, 64'hFFFF_FFFF_0000_0000, 32);
    run_op("u32 quo", 1'b0, 1'b0, E32, A32, B32, 64'h4000_0000_0000_0001, 32);
    run_op("u32 rem", 1'b0, 1'b1, E32, A32, B32, 64'h0000_0001_0000_0000, 32);

    // 64-bit
    run_op("u64 quo", 1'b0, 1'b0, E64, 64'd100, 64'd7, 64'd14, 64);
    run_op("u64 rem", 1'b0, 1'b1, E64, 64'd100, 64'd7, 64'd2, 64);
    run_op("s64 neg quo", 1'b1, 1'b0, E64, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64);
    run_op("s64 neg rem", 1'b1, 1'b1, E64, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_op("s64 ovf quo", 1'b1, 1'b0, E64, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64);
    run_op("s64 ovf rem", 1'b1, 1'b1, E64, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64);
    run_op("u64 dz quo", 1'b0, 1'b0, E64, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("u64 dz rem", 1'b0, 1'b1, E64, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF, 64);

    // Non-one-hot widths behave as 64-bit
    run_op("sew 0011", 1'b0, 1'b0, 4'b0011, 64'd100, 64'd7, 64'd14, 64);
    run_op("sew 0000", 1'b0, 1'b1, 4'b0000, 64'd100, 64'd7, 64'd2, 64);

    // Backpressure: hold DONE for 5 cycles, then hand off to a new op
    @(negedge clk);
    drive(1'b1, 1'b0, E8, A8, B8);
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_valid(lat, rdy_busy);
    check("bp latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid_o", 64'(valid_o), 64'd1);
      check("bp hold result", result, 64'h0EF2_8180_FF00_02FD);
      check("bp hold ready_o", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    drive(1'b1, 1'b1, E16, A16, B16);
    #1;
    check("handoff ready_o", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    check("handoff valid_o low", 64'(valid_o), 64'd0);
    check("handoff busy", 64'(ready_o), 64'd0);
    wait_valid(lat, rdy_busy);
    check("handoff latency", 64'(lat), 64'd16);
    check("handoff result", result, 64'hFFFA_000F_1234_0000);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;

    // Reset while BUSY with counter at 3
    @(negedge clk);
    drive(1'b0, 1'b0, E8, A8, B8);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset valid_o", 64'(valid_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid reset valid_o", 64'(valid_o), 64'd0);
    check("mid reset result", result, 64'd0);
    check("mid reset ready_o", 64'(ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset ready_o", 64'(ready_o), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    check("no stale result", 64'(seen), 64'd0);
    check("result stays zero", result, 64'd0);

    run_op("after reset", 1'b0, 1'b0, E8, A8, B8, 64'h0E16_0000_FF55_027C, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
